cpu_clk_ctrl: RTL
=================

Name: cpu_clk_ctrl

Overview:
- Run/step/halt controller that schedules the CPU pipeline's clock-enable from the board clock.
- Replaces free-running division with three modes: programmable-rate free run, debounced single-step, and halt on a CPU breakpoint.
- Sits between the board clock/switches and the 5-stage pipeline. Every pipeline register is gated by cpu_ce.
- Also exports a retired-tick counter for the debug display.

Parameters:
- DB_CYCLES, 20000: consecutive stable clk_in cycles before the debounced button level updates.
- CNT_W, 32: width of cycle_cnt.

Ports:
- clk_in, input, 1: board clock; the only clock in the block.
- rst_n, input, 1: asynchronous, active-low reset.
- run_sw, input, 1: asynchronous level; 1 requests free run.
- step_btn, input, 1: raw asynchronous push button; each press is one step.
- div_sel, input, 3: run-mode tick period P = 2^div_sel clk_in cycles (1..128). Quasi-static.
- halt_req, input, 1: synchronous to clk_in, from the CPU (ebreak/breakpoint hit).
- cpu_ce, output, 1: one-clk_in-cycle clock-enable pulse for the pipeline.
- halted, output, 1: 1 while the FSM is in HALT.
- cycle_cnt, output, CNT_W: number of cpu_ce pulses issued since reset.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=HALT, cpu_ce=0, halted=1, cycle_cnt=0.
  - div_cnt=0, halt_latch=0.
  - All synchronizer flops=0, btn_db=0, debounce counter=0.
- Input conditioning:
  - run_sw passes through a 2-flop synchronizer, giving run_s.
  - step_btn passes through a 2-flop synchronizer, then the debouncer.
  - Debouncer: while the synced level differs from btn_db, the counter increments; any match clears it. When the counter reaches DB_CYCLES-1, btn_db takes the new level and the counter clears.
  - step_evt is a 1-cycle pulse on each btn_db 0->1 transition. Release and bounce produce no event.
- halt_latch:
  - Set on any cycle with halt_req=1.
  - Cleared on the cycle after run_s falls. The user must toggle run off->on to resume after a breakpoint.
- FSM states: HALT, RUN, STEP.
  - HALT -> RUN when run_s=1, halt_latch=0 and halt_req=0. On entry to RUN, div_cnt is loaded with 0.
  - HALT -> STEP when step_evt=1 and the RUN condition is false. Stepping is allowed while halt_latch=1.
  - RUN:
    - If div_cnt >= P-1: cpu_ce=1 and div_cnt<=0. Otherwise div_cnt++.
    - Using >= makes a div_sel decrease mid-run take effect without a long wrap.
    - The first pulse falls on the P-th cycle spent in RUN. With P=1, cpu_ce=1 every RUN cycle.
  - RUN -> HALT when run_s=0 or halt_req=1.
  - STEP: cpu_ce=1 for exactly that one cycle; the next state is always HALT.
  - step_evt in RUN or STEP is ignored, not queued.
- cpu_ce = (RUN && div_cnt>=P-1 || STEP) && !halt_req.
  - halt_req suppresses the pulse in the same cycle, so no instruction advances past a breakpoint.
  - cpu_ce is never high in HALT.
- halted = (state==HALT); it is a registered state decode.
- cycle_cnt increments by 1 in every cycle with cpu_ce=1 and wraps modulo 2^CNT_W. Only reset clears it.
- Simultaneous events:
  - run_s=0 and halt_req=1 together: go to HALT, set halt_latch; it is cleared the next cycle because run_s=0.
  - step_evt and run_s=1 in HALT: RUN wins.
- Reset mid-operation: all state returns to reset values at once, with no pending pulse.

Test Plan (DB_CYCLES=4, CNT_W=32):
- Reset, run_sw=0, step_btn=0, 20 cycles -> cpu_ce never 1, halted=1, cycle_cnt=0.
- div_sel=2, raise run_sw, hold 40 cycles:
  - RUN is entered 2-3 cycles after run_sw rises (synchronizer).
  - cpu_ce pulses on the 4th RUN cycle, then every 4 cycles.
  - cycle_cnt = number of pulses; lower run_sw -> halted=1 within 3 cycles, no further pulses.
- Halted, step_btn bounces 1-0-1-0 at 1-cycle spacing, then held high 10 cycles, then low:
  - Exactly one cpu_ce pulse, occurring 2 sync cycles + 4 debounce cycles + FSM cycles after the stable rise.
  - cycle_cnt +1, no pulse on release.
- Running at div_sel=0, halt_req pulsed 1 cycle:
  - cpu_ce=0 in that cycle, then HALT.
  - With run_sw still 1, the FSM stays halted; one step press still gives one pulse.
  - Toggling run_sw 1->0->1 resumes RUN.
- Running at div_sel=7, switch to div_sel=0 mid-count (div_cnt=50) -> pulse on the next cycle, then every cycle.
- Assert rst_n=0 mid-RUN with div_cnt nonzero -> cpu_ce=0 and halted=1 immediately (async), cycle_cnt=0.

Source files
------------

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt clock-enable scheduler for the pipeline: programmable-rate free run,
// debounced single-step, and breakpoint halt, plus a count of issued enables.
module cpu_clk_ctrl #(
    parameter int DB_CYCLES = 20000,
    parameter int CNT_W     = 32
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic [2:0]       div_sel,
    input  logic             halt_req,
    output logic             cpu_ce,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HALT,
        ST_RUN,
        ST_STEP
    } state_t;

    state_t           state_q, state_d;
    logic             run_meta_q, run_meta_d;
    logic             run_s_q, run_s_d;
    logic             btn_meta_q, btn_meta_d;
    logic             btn_s_q, btn_s_d;
    logic             btn_db_q, btn_db_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             step_evt_q, step_evt_d;
    logic             halt_latch_q, halt_latch_d;
    logic [6:0]       div_cnt_q, div_cnt_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [6:0]       period_m1;
    logic             tick_due;

    always_comb begin
        run_meta_d = run_sw;
        run_s_d    = run_meta_q;
        btn_meta_d = step_btn;
        btn_s_d    = btn_meta_q;

        // The button level only moves after DB_CYCLES consecutive disagreeing samples.
        btn_db_d   = btn_db_q;
        db_cnt_d   = '0;
        step_evt_d = 1'b0;
        if (btn_s_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d   = btn_s_q;
                step_evt_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        if (halt_req) begin
            halt_latch_d = 1'b1;
        end else if (!run_s_q) begin
            halt_latch_d = 1'b0;
        end else begin
            halt_latch_d = halt_latch_q;
        end
    end

    // Comparing with >= lets a shorter period take effect without wrapping the counter.
    assign period_m1 = 7'((8'd1 << div_sel) - 8'd1);
    assign tick_due  = (div_cnt_q >= period_m1);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        cpu_ce    = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (run_s_q && !halt_latch_q && !halt_req) begin
                    state_d   = ST_RUN;
                    div_cnt_d = '0;
                end else if (step_evt_q) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                cpu_ce    = tick_due && !halt_req;
                div_cnt_d = tick_due ? 7'd0 : div_cnt_q + 7'd1;
                if (!run_s_q || halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                cpu_ce  = !halt_req;
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
        halted_d    = (state_d == ST_HALT);
        cycle_cnt_d = cycle_cnt_q + {{(CNT_W-1){1'b0}}, cpu_ce};
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HALT;
            run_meta_q   <= 1'b0;
            run_s_q      <= 1'b0;
            btn_meta_q   <= 1'b0;
            btn_s_q      <= 1'b0;
            btn_db_q     <= 1'b0;
            db_cnt_q     <= '0;
            step_evt_q   <= 1'b0;
            halt_latch_q <= 1'b0;
            div_cnt_q    <= '0;
            halted_q     <= 1'b1;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            run_meta_q   <= run_meta_d;
            run_s_q      <= run_s_d;
            btn_meta_q   <= btn_meta_d;
            btn_s_q      <= btn_s_d;
            btn_db_q     <= btn_db_d;
            db_cnt_q     <= db_cnt_d;
            step_evt_q   <= step_evt_d;
            halt_latch_q <= halt_latch_d;
            div_cnt_q    <= div_cnt_d;
            halted_q     <= halted_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign halted    = halted_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
